// File: rtl/sha3_unpadder_if.sv
// Stream interface for the SHA3 unpadder: padded rate-block words in,
// recovered message words out, plus the pad-error pulse.
interface sha3_unpadder_if;
  logic [31:0] in;
  logic        in_valid;
  logic        in_last_block;
  logic        in_ready;
  logic [31:0] out;
  logic [1:0]  out_byte_num;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        pad_err;

  modport master (
    output in, in_valid, in_last_block, out_ready,
    input  in_ready, out, out_byte_num, out_last, out_valid, pad_err
  );

  modport slave (
    input  in, in_valid, in_last_block, out_ready,
    output in_ready, out, out_byte_num, out_last, out_valid, pad_err
  );
endinterface

// File: rtl/sha3_unpadder.sv
// SHA3 unpadder: buffers one rate block, strips the 0x06..0x80 pad from the
// final block and streams the message words with a final valid-byte count.
module sha3_unpadder #(
  parameter int         RATE_WORDS = 18,
  parameter logic [7:0] PAD_BYTE   = 8'h06
) (
  input logic            clk,
  input logic            reset,
  sha3_unpadder_if.slave bus
);

  localparam int CW = $clog2(RATE_WORDS + 1);
  localparam int LW = $clog2(4 * RATE_WORDS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(RATE_WORDS - 1);

  typedef enum logic [1:0] {FILL, SCAN, DRAIN} state_t;

  state_t        state;
  logic [31:0]   buffer [RATE_WORDS];
  logic [CW-1:0] cnt;
  logic [CW-1:0] ptr;
  logic [CW-1:0] oi;
  logic [LW-1:0] len;
  logic          last_blk;
  logic          fin_word;

  logic [31:0]   scan_word;
  logic          found;
  logic [1:0]    b_idx;
  logic [7:0]    b_val;
  logic          blk_final;
  logic          drain_is_last;
  logic [31:0]   drain_word;

  // Zero every byte whose index is nb or higher (byte 0 is the MSB).
  function automatic logic [31:0] mask_tail(input logic [31:0] w, input logic [1:0] nb);
    logic [31:0] r;
    r = w;
    for (int k = 0; k < 4; k++)
      if (k >= int'(nb)) r[31-8*k -: 8] = 8'h00;
    return r;
  endfunction

  always_comb begin
    scan_word = buffer[ptr];
    // The closing 0x80 bit is removed so a merged 0x86 byte reads as the pad start.
    if (ptr == LAST_IDX) scan_word[7] = 1'b0;
    found = 1'b0;
    b_idx = 2'd0;
    b_val = 8'h00;
    for (int k = 0; k < 4; k++) begin
      if (scan_word[31-8*k -: 8] != 8'h00) begin
        found = 1'b1;
        b_idx = 2'(k);
        b_val = scan_word[31-8*k -: 8];
      end
    end
    blk_final     = (cnt == '0) ? bus.in_last_block : last_blk;
    drain_is_last = last_blk && (oi == CW'(len >> 2));
    drain_word    = drain_is_last ? mask_tail(buffer[oi], len[1:0]) : buffer[oi];
  end

  always_ff @(posedge clk) begin
    if (state == FILL && bus.in_valid && bus.in_ready) buffer[cnt] <= bus.in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= FILL;
      cnt              <= '0;
      fin_word         <= 1'b0;
      bus.in_ready     <= 1'b1;
      bus.out_valid    <= 1'b0;
      bus.out_last     <= 1'b0;
      bus.out_byte_num <= 2'd0;
      bus.out          <= 32'h0;
      bus.pad_err      <= 1'b0;
    end else begin
      bus.pad_err <= 1'b0;
      case (state)
        FILL: begin
          if (bus.in_valid && bus.in_ready) begin
            if (cnt == '0) last_blk <= bus.in_last_block;
            if (cnt == LAST_IDX) begin
              cnt          <= '0;
              bus.in_ready <= 1'b0;
              ptr          <= LAST_IDX;
              oi           <= '0;
              len          <= LW'(4 * RATE_WORDS);
              state        <= blk_final ? SCAN : DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        SCAN: begin
          if ((ptr == LAST_IDX && !buffer[LAST_IDX][7]) ||
              (!found && ptr == '0) ||
              (found && b_val != PAD_BYTE)) begin
            bus.pad_err  <= 1'b1;
            bus.in_ready <= 1'b1;
            state        <= FILL;
          end else if (!found) begin
            ptr <= ptr - 1'b1;
          end else begin
            len   <= (LW'(ptr) << 2) | LW'(b_idx);
            oi    <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.out_valid && bus.out_ready && fin_word) begin
            bus.out_valid    <= 1'b0;
            bus.out_last     <= 1'b0;
            bus.out_byte_num <= 2'd0;
            bus.in_ready     <= 1'b1;
            state            <= FILL;
          end else if (!bus.out_valid || bus.out_ready) begin
            bus.out          <= drain_word;
            bus.out_valid    <= 1'b1;
            bus.out_last     <= drain_is_last;
            bus.out_byte_num <= drain_is_last ? len[1:0] : 2'd0;
            fin_word         <= drain_is_last || (!last_blk && oi == LAST_IDX);
            oi               <= oi + 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_unpadder.sv
// Randomized bench for sha3_unpadder against a byte-level unpadding model.
module tb_sha3_unpadder;
  localparam int RW = 18;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sha3_unpadder_if bus();

  sha3_unpadder #(.RATE_WORDS(RW), .PAD_BYTE(8'h06)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] blk [RW];
  logic [31:0] exp_w [$];
  logic        exp_last [$];
  logic [1:0]  exp_bn [$];
  logic        exp_err;

  // Reference: flatten to bytes, drop the 0x80 bit, last nonzero byte must be 0x06.
  task automatic model(input logic fin);
    logic [7:0]  by [4*RW];
    logic [31:0] w;
    int idx, len;
    exp_w.delete(); exp_last.delete(); exp_bn.delete();
    exp_err = 1'b0;
    if (!fin) begin
      for (int k = 0; k < RW; k++) begin
        exp_w.push_back(blk[k]); exp_last.push_back(1'b0); exp_bn.push_back(2'd0);
      end
      return;
    end
    for (int i = 0; i < 4*RW; i++) by[i] = blk[i/4][31-8*(i%4) -: 8];
    if (!by[4*RW-1][7]) begin exp_err = 1'b1; return; end
    by[4*RW-1][7] = 1'b0;
    idx = -1;
    for (int i = 0; i < 4*RW; i++) if (by[i] != 8'h00) idx = i;
    if (idx < 0 || by[idx] != 8'h06) begin exp_err = 1'b1; return; end
    len = idx;
    for (int k = 0; k <= len/4; k++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) if (4*k + j < len) w[31-8*j -: 8] = by[4*k + j];
      exp_w.push_back(w);
      exp_last.push_back(k == len/4);
      exp_bn.push_back((k == len/4) ? 2'(len % 4) : 2'd0);
    end
  endtask

  task automatic gen_final(input int len, input logic corrupt);
    logic [7:0] by [4*RW];
    for (int i = 0; i < 4*RW; i++) by[i] = (i < len) ? 8'($urandom) : 8'h00;
    by[len] = corrupt ? 8'h07 : 8'h06;
    by[4*RW-1] = by[4*RW-1] | 8'h80;
    for (int k = 0; k < RW; k++) blk[k] = {by[4*k], by[4*k+1], by[4*k+2], by[4*k+3]};
  endtask

  task automatic clear_blk();
    for (int k = 0; k < RW; k++) blk[k] = 32'h0;
  endtask

  task automatic run_block(input logic fin, input int stall_at, input int abort_at, input string name);
    int wi = 0, oi = 0, cyc = 0, stall = 0;
    logic done = 1'b0, err_seen = 1'b0, aborted = 1'b0, prev_pend = 1'b0;
    logic [31:0] prev_out = 32'h0;
    logic prev_last = 1'b0;
    model(fin);
    while (!done && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (prev_pend) begin
        chk({name, " hold_data"}, bus.out, prev_out);
        chk({name, " hold_last"}, 32'(bus.out_last), 32'(prev_last));
      end
      if (wi < RW) begin
        bus.in_valid      = 1'b1;
        bus.in            = blk[wi];
        bus.in_last_block = (wi == 0) ? fin : 1'($urandom);
        if (bus.in_ready) wi++;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (stall_at >= 0 && oi == stall_at && stall < 5) begin
        bus.out_ready = 1'b0;
        stall++;
      end else begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      if (bus.pad_err) begin
        chk({name, " pad_err"}, 32'(bus.pad_err), 32'(exp_err));
        err_seen = 1'b1;
      end
      if (bus.out_valid) begin
        if (exp_err || oi >= exp_w.size()) begin
          chk({name, " extra_word"}, 32'(bus.out_valid), 32'd0);
        end else if (bus.out_ready) begin
          chk({name, " data"}, bus.out, exp_w[oi]);
          chk({name, " last"}, 32'(bus.out_last), 32'(exp_last[oi]));
          chk({name, " byte_num"}, 32'(bus.out_byte_num), 32'(exp_bn[oi]));
          oi++;
        end
      end
      prev_pend = bus.out_valid && !bus.out_ready;
      prev_out  = bus.out;
      prev_last = bus.out_last;
      if (abort_at >= 0 && oi == abort_at) begin
        done = 1'b1; aborted = 1'b1;
      end else if (exp_err ? err_seen : (oi == exp_w.size())) begin
        done = 1'b1;
      end
    end
    if (!done) chk({name, " timeout"}, 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    if (aborted) begin
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk({name, " abort_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({name, " abort_in_ready"}, 32'(bus.in_ready), 32'd1);
    end else begin
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk({name, " post_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({name, " post_in_ready"}, 32'(bus.in_ready), 32'd1);
      chk({name, " post_pad_err"}, 32'(bus.pad_err), 32'd0);
    end
  endtask

  initial begin
    bus.in = 32'h0; bus.in_valid = 1'b0; bus.in_last_block = 1'b0; bus.out_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_last", 32'(bus.out_last), 32'd0);
    chk("rst byte_num", 32'(bus.out_byte_num), 32'd0);
    chk("rst out", bus.out, 32'd0);
    chk("rst pad_err", 32'(bus.pad_err), 32'd0);
    reset = 1'b1;

    clear_blk(); blk[0] = 32'h11223344; blk[1] = 32'h55060000; blk[RW-1] = 32'h00000080;
    run_block(1'b1, -1, -1, "deep_scan");

    for (int k = 0; k < RW; k++) blk[k] = 32'(k);
    blk[RW-1] = 32'hAABBCC86;
    run_block(1'b1, -1, -1, "merged_pad");

    clear_blk(); blk[0] = 32'hDEADBEEF; blk[1] = 32'h01020304; blk[2] = 32'hFFFFFFFF;
    blk[3] = 32'h06000000; blk[RW-1] = 32'h00000080;
    run_block(1'b1, -1, -1, "aligned_len");

    for (int k = 0; k < RW; k++) blk[k] = 32'h00010203 + 32'(k);
    run_block(1'b0, -1, -1, "nonfinal");
    clear_blk(); blk[0] = 32'h06000000; blk[RW-1] = 32'h00000080;
    run_block(1'b1, -1, -1, "empty_msg");

    clear_blk();
    run_block(1'b1, -1, -1, "err_no_end");
    clear_blk(); blk[0] = 32'h07000000; blk[RW-1] = 32'h00000080;
    run_block(1'b1, -1, -1, "err_bad_start");
    clear_blk(); blk[0] = 32'h06000000; blk[RW-1] = 32'h00000006;
    run_block(1'b1, -1, -1, "err_no_bit7");

    for (int k = 0; k < RW; k++) blk[k] = $urandom;
    run_block(1'b0, 3, -1, "stall");
    for (int k = 0; k < RW; k++) blk[k] = $urandom;
    run_block(1'b0, -1, 4, "abort");
    gen_final(37, 1'b0);
    run_block(1'b1, -1, -1, "after_abort");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < RW; k++) blk[k] = $urandom;
        run_block(1'b0, -1, -1, "rand_nonfinal");
      end else begin
        gen_final($urandom_range(0, 4*RW-1), ($urandom_range(0, 7) == 0));
        run_block(1'b1, -1, -1, "rand_final");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sha3_unpadder.md
Name: sha3_unpadder

Overview:
- Inverse of the SHA3 word padder: takes a stream of padded 32-bit rate-block words and recovers the original message words with a final valid-byte count.
- Buffers one full rate block, locates the SHA3 pad (0x06 ... 0x80) in the final block, strips it and emits message words.
- Sits on the verification/loopback path after the padder and block assembler; also checks pad integrity.

Parameters:
- RATE_WORDS, 18, words per rate block (576 bits, SHA3-512).
- PAD_BYTE, 8'h06, domain-separation pad start byte.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in  in  32  padded word; byte 0 at [31:24], byte 3 at [7:0]
- in_valid  in  1  input word valid
- in_last_block  in  1  sampled with the first word of a block; 1 = final (padded) block
- in_ready  out  1  buffer accepting words
- out  out  32  message word; bytes at or beyond out_byte_num zeroed on the last word
- out_byte_num  out  2  valid bytes in the last word (0..3); 0 on non-last words
- out_last  out  1  final message word
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- pad_err  out  1  one-cycle pulse: malformed padding, block discarded

Behaviour:
- Reset (reset==0 at a clk edge): state FILL, word counter 0, in_ready=1, out_valid=0, out_last=0, out_byte_num=0, out=0, pad_err=0. Buffer contents need not be cleared. Reset mid-SCAN or mid-DRAIN aborts the block; no further output words.
- Transfers occur on valid&ready at the rising edge.
- FILL:
  - Accept words into buffer[cnt], cnt 0..RATE_WORDS-1.
  - Latch in_last_block on the cnt==0 transfer.
  - On the transfer at cnt==RATE_WORDS-1 go to DRAIN with len=4*RATE_WORDS if not final, else SCAN.
  - in_ready=1 only in FILL.
- SCAN (final block only), pointer p starts at RATE_WORDS-1, one word examined per cycle:
  - Byte 3 of word RATE_WORDS-1 must have bit 7 set, else pad_err and return to FILL. That bit is masked to 0 for the search (0x86 becomes 0x06).
  - In word p, find the highest-index nonzero byte b.
    - If none: p--. If p was 0, pad_err and return to FILL.
    - If found: the byte must equal PAD_BYTE, else pad_err and return to FILL. Otherwise len = 4*p + b, go to DRAIN.
  - Scan latency is RATE_WORDS - p cycles.
- DRAIN:
  - Non-final block: emit words 0..RATE_WORDS-1 unchanged, out_last=0, out_byte_num=0.
  - Final block: emit words 0..floor(len/4)-1 unchanged, then word floor(len/4) with bytes >= len%4 zeroed, out_last=1, out_byte_num=len%4. A last word is always emitted, including len%4==0.
  - out, out_last and out_byte_num are held stable while out_valid&!out_ready.
  - After the final handshake: out_valid=0, return to FILL, in_ready=1 on the next cycle.
- pad_err is high for exactly one cycle. No words of an errored block are emitted.
- No back-to-back overlap: the next block is accepted only after the current one fully drains.

Test Plan:
- Final block, words 0x11223344, 0x55060000, 0x0 x15, 0x00000080 -> scan 17 cycles. Output 0x11223344 (last=0), then 0x55000000 (last=1, byte_num=1).
- Final block, word 17 = 0xAABBCC86, words 0..16 = index values -> scan 1 cycle. Words 0..16 unchanged, then 0xAABBCC00 (last=1, byte_num=3).
- Final block, word 3 = 0x06000000, words 4..16 = 0, word 17 = 0x00000080 -> 3 full words, then 0x00000000 (last=1, byte_num=0).
- Non-final block of 18 words 0x00010203+i, then final block of 0x80-only padding -> first 18 words output unchanged with last=0. Second block: 0x06 in word 0 byte 0 gives single word 0x00000000 (last=1, byte_num=0).
- Word 17 = 0x00000000, or first nonzero byte 0x07 -> pad_err pulses 1 cycle, no out_valid, in_ready=1 the next cycle.
- out_ready held low 5 cycles mid-drain -> out stable, no word lost or duplicated. reset=0 mid-drain -> out_valid=0 and in_ready=1 after the edge; the following block drains correctly.
